// File: rtl/lane_request_gen.sv
// Purpose: debounce six vehicle detectors into sticky lane requests, retired by the served lamp.
// Latency: request rises DEB+2 edges after first det capture; clears on the serving lamp edge.
// Backpressure: none; a request is held until served, re-arm needs the detector to release.
module lane_request_gen #(
   parameter int DEB      = 4,
   parameter int WAIT_MAX = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] det,
   input  logic [3:0] N,
   input  logic [3:0] W,
   input  logic [3:0] E,
   input  logic [3:0] S,
   output logic       L_1,
   output logic       L_2,
   output logic       L_3,
   output logic       L_4,
   output logic       L_5,
   output logic       L_6,
   output logic [5:0] starve,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_DONE = 2'd2
   } lane_st_t;

   localparam logic [3:0]  DEB_LAST = 4'(DEB - 1);
   localparam logic [15:0] WC_MAX   = 16'(WAIT_MAX);
   localparam logic [15:0] WC_LAST  = 16'(WAIT_MAX - 1);

   logic [5:0]  s1_q, s1_d;
   logic [5:0]  s2_q, s2_d;
   logic [5:0]  starve_q, starve_d;
   lane_st_t    st_q [6];
   lane_st_t    st_d [6];
   logic [3:0]  dc_q [6];
   logic [3:0]  dc_d [6];
   logic [15:0] wc_q [6];
   logic [15:0] wc_d [6];
   logic [5:0]  srv;
   logic [5:0]  lreq;
   logic        unused_lamp_bits;

   // Only the two upper lamp bits of each head signal service.
   assign unused_lamp_bits = ^{N[1:0], W[1:0], E[1:0], S[1:0]};

   // Map controller lamp outputs to the lane each one serves.
   always_comb begin
      srv    = '0;
      srv[0] = N[3];
      srv[1] = N[2] | S[2];
      srv[2] = S[3];
      srv[3] = W[3];
      srv[4] = W[2] | E[2];
      srv[5] = E[3];
   end

   // Two-flop synchroniser for the asynchronous detectors.
   always_comb begin
      s1_d = det;
      s2_d = s1_q;
   end

   // Per-lane request FSM: debounce in IDLE, wait for service in PEND, wait for release in DONE.
   always_comb begin
      for (int k = 0; k < 6; k++) begin
         st_d[k]     = st_q[k];
         dc_d[k]     = dc_q[k];
         wc_d[k]     = wc_q[k];
         starve_d[k] = starve_q[k];
         case (st_q[k])
            ST_IDLE: begin
               starve_d[k] = 1'b0;
               if (!s2_q[k]) begin
                  dc_d[k] = 4'd0;
               end else if (dc_q[k] == DEB_LAST) begin
                  st_d[k] = ST_PEND;
                  dc_d[k] = 4'd0;
                  wc_d[k] = 16'd0;
               end else begin
                  dc_d[k] = dc_q[k] + 4'd1;
               end
            end
            ST_PEND: begin
               if (srv[k]) begin
                  st_d[k]     = ST_DONE;
                  wc_d[k]     = 16'd0;
                  starve_d[k] = 1'b0;
               end else if (wc_q[k] != WC_MAX) begin
                  wc_d[k] = wc_q[k] + 16'd1;
                  // Flag on the edge where the wait count lands on the limit.
                  if (wc_q[k] == WC_LAST) begin
                     starve_d[k] = 1'b1;
                  end
               end
            end
            ST_DONE: begin
               starve_d[k] = 1'b0;
               // A parked car keeps the lane here; it must leave before re-arming.
               if (!s2_q[k]) begin
                  st_d[k] = ST_IDLE;
                  dc_d[k] = 4'd0;
               end
            end
            default: begin
               st_d[k]     = ST_IDLE;
               dc_d[k]     = 4'd0;
               wc_d[k]     = 16'd0;
               starve_d[k] = 1'b0;
            end
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q     <= '0;
         s2_q     <= '0;
         starve_q <= '0;
         for (int k = 0; k < 6; k++) begin
            st_q[k] <= ST_IDLE;
            dc_q[k] <= 4'd0;
            wc_q[k] <= 16'd0;
         end
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         starve_q <= starve_d;
         for (int k = 0; k < 6; k++) begin
            st_q[k] <= st_d[k];
            dc_q[k] <= dc_d[k];
            wc_q[k] <= wc_d[k];
         end
      end
   end

   // Requests come straight from the registered lane state.
   always_comb begin
      for (int k = 0; k < 6; k++) begin
         lreq[k] = (st_q[k] == ST_PEND);
      end
   end

   assign L_1    = lreq[0];
   assign L_2    = lreq[1];
   assign L_3    = lreq[2];
   assign L_4    = lreq[3];
   assign L_5    = lreq[4];
   assign L_6    = lreq[5];
   assign starve = starve_q;
   assign busy   = |lreq;

endmodule

// File: tb/tb_lane_request_gen.sv
// Bench for lane_request_gen: directed scenarios plus random detector/lamp traffic,
// compared every edge against a lane model built from request/served/released rules
// and a per-lane count of edges spent waiting.
module tb_lane_request_gen;

   localparam int DEB      = 4;
   localparam int WAIT_MAX = 20;

   logic       clk;
   logic       rst;
   logic [5:0] det;
   logic [3:0] N, W, E, S;
   logic       L_1, L_2, L_3, L_4, L_5, L_6;
   logic [5:0] starve;
   logic       busy;
   logic [12:0] obs_vec;

   int n_cmp;
   int n_fail;

   // Reference model state.
   logic [5:0] m_s1, m_s2;
   bit         m_req [6];
   bit         m_blk [6];
   int         m_run [6];
   int         m_pend [6];

   lane_request_gen #(.DEB(DEB), .WAIT_MAX(WAIT_MAX)) dut (
      .clk    (clk),
      .rst    (rst),
      .det    (det),
      .N      (N),
      .W      (W),
      .E      (E),
      .S      (S),
      .L_1    (L_1),
      .L_2    (L_2),
      .L_3    (L_3),
      .L_4    (L_4),
      .L_5    (L_5),
      .L_6    (L_6),
      .starve (starve),
      .busy   (busy)
   );

   assign obs_vec = {L_6, L_5, L_4, L_3, L_2, L_1, starve, busy};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance the model by one edge using the inputs that were stable at that edge.
   task automatic model_edge();
      logic [5:0] sv;
      sv = {E[3], W[2] | E[2], W[3], S[3], N[2] | S[2], N[3]};
      if (rst) begin
         m_s1 = '0;
         m_s2 = '0;
         for (int k = 0; k < 6; k++) begin
            m_req[k] = 0; m_blk[k] = 0; m_run[k] = 0; m_pend[k] = 0;
         end
      end else begin
         for (int k = 0; k < 6; k++) begin
            if (m_req[k]) begin
               if (sv[k]) begin
                  m_req[k] = 0;
                  m_blk[k] = 1;
               end else begin
                  m_pend[k]++;
               end
            end else if (m_blk[k]) begin
               if (!m_s2[k]) begin
                  m_blk[k] = 0;
                  m_run[k] = 0;
               end
            end else if (m_s2[k]) begin
               m_run[k]++;
               if (m_run[k] == DEB) begin
                  m_req[k]  = 1;
                  m_run[k]  = 0;
                  m_pend[k] = 0;
               end
            end else begin
               m_run[k] = 0;
            end
         end
         m_s2 = m_s1;
         m_s1 = det;
      end
   endtask

   function automatic logic [12:0] exp_vec();
      logic [5:0] l, st;
      for (int k = 0; k < 6; k++) begin
         l[k]  = m_req[k];
         st[k] = m_req[k] && (m_pend[k] >= WAIT_MAX);
      end
      return {l, st, |l};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; det = '0; N = '0; W = '0; E = '0; S = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; det = 6'h3F; N = '0; W = '0; E = '0; S = '0;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if (obs_vec !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_hold step=%0d got=%h want=%h", i, obs_vec, 13'h0);
         end
      end
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         logic [12:0] want;
         tick();
         want = (i == 5) ? {6'h3F, 6'h00, 1'b1} : 13'h0;
         n_cmp++;
         if (obs_vec !== want) begin
            n_fail++;
            $display("FAIL reset_release step=%0d got=%h want=%h", i, obs_vec, want);
         end
         n_cmp++;
         if (obs_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_model step=%0d got=%h want=%h", i, obs_vec, exp_vec());
         end
      end
   endtask

   task automatic test_debounce();
      do_reset();
      for (int i = 0; i < 12; i++) begin
         logic want;
         det[0] = (i < 3) || (i >= 4);
         tick();
         want = (i >= 9);
         n_cmp++;
         if (L_1 !== want || busy !== want) begin
            n_fail++;
            $display("FAIL debounce step=%0d got L_1=%b busy=%b want=%b", i, L_1, busy, want);
         end
         n_cmp++;
         if (obs_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL debounce_model step=%0d got=%h want=%h", i, obs_vec, exp_vec());
         end
      end
   endtask

   task automatic test_service();
      do_reset();
      det = 6'b010010;
      for (int i = 0; i < 6; i++) tick();
      n_cmp++;
      if ({L_2, L_5} !== 2'b11) begin
         n_fail++;
         $display("FAIL service_pend got=%b want=11", {L_2, L_5});
      end
      S = 4'b0100;
      tick();
      n_cmp++;
      if ({L_2, L_5} !== 2'b01) begin
         n_fail++;
         $display("FAIL service_south got=%b want=01", {L_2, L_5});
      end
      S = 4'b0000; W = 4'b0100;
      tick();
      n_cmp++;
      if ({L_2, L_5, busy} !== 3'b000) begin
         n_fail++;
         $display("FAIL service_west got=%b want=000", {L_2, L_5, busy});
      end
      W = 4'b0000; det = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (obs_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL service_model step=%0d got=%h want=%h", i, obs_vec, exp_vec());
         end
      end
   endtask

   task automatic test_rearm();
      do_reset();
      det = 6'b000001;
      for (int i = 0; i < 6; i++) tick();
      N = 4'b1000;
      tick();
      N = 4'b0000;
      n_cmp++;
      if (L_1 !== 1'b0) begin
         n_fail++;
         $display("FAIL rearm_served got=%b want=0", L_1);
      end
      for (int i = 0; i < 50; i++) begin
         tick();
         n_cmp++;
         if (L_1 !== 1'b0 || obs_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL rearm_parked step=%0d got=%h want=%h", i, obs_vec, exp_vec());
         end
      end
      det = 6'b000000;
      tick();
      det = 6'b000001;
      for (int i = 0; i < 6; i++) begin
         logic want;
         tick();
         want = (i == 5);
         n_cmp++;
         if (L_1 !== want) begin
            n_fail++;
            $display("FAIL rearm_return step=%0d got=%b want=%b", i, L_1, want);
         end
      end
   endtask

   task automatic test_starve();
      do_reset();
      det = 6'b001000;
      for (int i = 0; i < 6; i++) tick();
      det = '0;
      W = 4'b0001;
      for (int i = 1; i <= 22; i++) begin
         logic want;
         tick();
         want = (i >= WAIT_MAX);
         n_cmp++;
         if (starve[3] !== want || L_4 !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_wait edge=%0d got L_4=%b starve=%b want L_4=1 starve=%b",
                     i, L_4, starve[3], want);
         end
         n_cmp++;
         if (obs_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL starve_model edge=%0d got=%h want=%h", i, obs_vec, exp_vec());
         end
      end
      W = 4'b1000;
      tick();
      W = 4'b0000;
      n_cmp++;
      if ({L_4, starve[3]} !== 2'b00) begin
         n_fail++;
         $display("FAIL starve_clear got=%b want=00", {L_4, starve[3]});
      end
   endtask

   task automatic test_reset_midpend();
      do_reset();
      det = 6'b100000;
      for (int i = 0; i < 6 + WAIT_MAX; i++) tick();
      n_cmp++;
      if ({L_6, starve[5]} !== 2'b11) begin
         n_fail++;
         $display("FAIL midpend_setup got=%b want=11", {L_6, starve[5]});
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if ({L_6, starve[5], busy} !== 3'b000) begin
         n_fail++;
         $display("FAIL midpend_reset got=%b want=000", {L_6, starve[5], busy});
      end
      for (int i = 0; i < 6; i++) begin
         logic want;
         tick();
         want = (i == 5);
         n_cmp++;
         if (L_6 !== want || obs_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL midpend_rerequest step=%0d got=%h want=%h", i, obs_vec, exp_vec());
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 7) == 0) det[k] = ~det[k];
         end
         N   = 4'($urandom) & 4'($urandom) & 4'($urandom);
         W   = 4'($urandom) & 4'($urandom) & 4'($urandom);
         E   = 4'($urandom) & 4'($urandom) & 4'($urandom);
         S   = 4'($urandom) & 4'($urandom) & 4'($urandom);
         rst = ($urandom_range(0, 299) == 0);
         tick();
         n_cmp++;
         if (obs_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL random step=%0d got=%h want=%h", n, obs_vec, exp_vec());
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst = 1'b1; det = '0; N = '0; W = '0; E = '0; S = '0;
      m_s1 = '0; m_s2 = '0;
      for (int k = 0; k < 6; k++) begin
         m_req[k] = 0; m_blk[k] = 0; m_run[k] = 0; m_pend[k] = 0;
      end
      test_reset();
      test_debounce();
      test_service();
      test_rearm();
      test_starve();
      test_reset_midpend();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/lane_request_gen.md
# lane_request_gen

Detector front end that produces the six lane-request lines L_1..L_6 consumed by the intersection light controller, and retires each request by reading back that controller's lamp outputs N/W/E/S. Each raw vehicle detector is synchronised, debounced, and latched as a sticky request. The request is held until the lamp serving that lane turns on, and is then cleared. Re-arming requires the detector to release. It also flags lanes that have waited too long (starvation) for the supervisor.

## Interface
- DEB, 4: consecutive synchronised-high samples needed to latch a request; legal 1..15.
- WAIT_MAX, 1000: cycles in pending before starve asserts; legal 1..65535.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; one clock, synchronous, active-high.
- det  input  6  raw detectors; det[k-1] is lane k. Asynchronous to clk.
- N  input  4  North lamp vector from controller.
- W  input  4  West lamp vector from controller.
- E  input  4  East lamp vector from controller.
- S  input  4  South lamp vector from controller.
- L_1 .. L_6  output  1 each  latched lane requests to the controller; registered.
- starve  output  6  starve[k-1] set while lane k pending for WAIT_MAX cycles; registered.
- busy  output  1  OR of L_1..L_6.

## Operation
- Synchroniser: det passes through two flops (s1, s2) per lane. Only s2 is used downstream.
- Service decode is combinational and is sampled each edge:
  - srv1 = N[3]
  - srv2 = N[2] | S[2]
  - srv3 = S[3]
  - srv4 = W[3]
  - srv5 = W[2] | E[2]
  - srv6 = E[3]
- Each lane has an independent 3-state FSM with a 4-bit debounce counter (dc) and a 16-bit wait counter (wc).
- IDLE (L=0, starve=0):
  - s2=0: dc<=0.
  - s2=1 and dc<DEB-1: dc<=dc+1.
  - s2=1 and dc==DEB-1: go to PEND; dc<=0, wc<=0.
  - srv is ignored in IDLE.
- PEND (L=1):
  - srv=1: go to DONE; wc<=0, starve<=0.
  - Otherwise wc<=wc+1, saturating at WAIT_MAX. starve<=1 on the edge where wc reaches WAIT_MAX.
  - Detector state is ignored in PEND.
- DONE (L=0, starve=0):
  - s2=0: go to IDLE, dc<=0.
  - s2=1: stay in DONE. A car parked on the detector does not re-request.
- Simultaneous events:
  - Debounce completes on the same edge srv is high: enter PEND anyway. srv is evaluated from the next edge.
  - Lanes are fully independent. Several lanes may pend or starve at once.
- Reset:
  - rst=1 at any edge forces all lanes to IDLE, clears s1, s2, dc, wc, and drives all L, starve, busy to 0.
  - rst dominates all other inputs, including mid-debounce and mid-pend.

## Timing
- Reset values: L_1..L_6=0, starve=0, busy=0, all FSMs in IDLE.
- Request latency: det[k-1] is held high and sampled high at edges t0, t1, ... The matching L_k rises after edge t(DEB+1), i.e. DEB+2 edges after first capture. With DEB=4, L_k rises after t5.
- Glitch rejection: a det low sample reaching s2 before dc hits DEB-1 restarts the count from 0. A pulse shorter than DEB cycles never requests.
- Clear latency: L_k falls after the first edge in PEND at which srv_k=1. Zero added delay relative to the lamp register.
- Starve: asserts after WAIT_MAX edges in PEND without service. It holds until the clearing edge and falls on the same edge as L_k.
- Re-arm: after DONE, det must be low through the synchroniser for at least one sample, then high for a full debounce, before L_k rises again.
- busy is combinational from registered L_k, so it has no added latency.

## Test plan
- Reset: hold rst for 2 cycles with det=6'h3F -> all outputs stay 0 throughout, and for 1 cycle after release. L_1..L_6 rise together 6 edges after the first post-reset sample (DEB=4).
- Debounce: det[0] high for 3 cycles, low 1, high 4 -> L_1 stays 0 after the first burst. L_1=1 after the 6th edge of the second burst. busy=1.
- Service decode: L_2 and L_5 pending; drive S=4'b0100 for 1 cycle -> L_2 falls on that edge, L_5 stays 1. Then W=4'b0100 -> L_5 falls.
- Re-arm: L_1 served while det[0] stays high for 50 cycles -> L_1 stays 0. Drop det[0] for 1 cycle then raise it -> L_1 returns after DEB+2 edges.
- Starvation (WAIT_MAX=20): L_4 pending, W=4'b0001 -> starve[3]=1 after 20 edges in PEND. Drive W=4'b1000 -> L_4 and starve[3] fall on the same edge.
- Reset mid-pend: L_6 pending with starve[5]=1, pulse rst for 1 cycle -> L_6, starve[5], busy are 0 after that edge. A held det[5] re-requests after DEB+2 edges.
